mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences a single-ported, fixed-latency unified memory between the pipelined core's instruction-fetch port and data-access port. Owns the memory bus: one outstanding transaction at a time, with data-over-fetch priority and alternation on contention. Returns one-cycle ready pulses that the core uses as stall releases for the IF and MEM stages. Also counts grants for performance monitoring.

## Interface
- LATENCY, 4, memory access cycles (mem_en high for exactly LATENCY cycles per access); legal range 1..15
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  AW  fetch address
- if_ready  out  1  one-cycle pulse: fetch done, if_rdata valid this cycle
- if_rdata  out  DW  fetch read data (= rdata_q)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ready  out  1  one-cycle pulse: data access done, d_rdata valid this cycle (loads)
- d_rdata  out  DW  load data (= rdata_q)
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in final cycle of access
- grant_cnt_i  out  32  completed fetch transactions, wraps at 2^32
- grant_cnt_d  out  32  completed data transactions, wraps at 2^32

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE: arbitrate on registered inputs.
  - d_req only: grant D. if_req only: grant I.
  - Both high: grant D unless last_grant == D, in which case grant I (alternation; last_grant resets to I).
  - On grant, latch we/addr/wdata into mem_* registers (mem_we forced 0 for I), set mem_en = 1, cnt = LATENCY-1, record gnt, go BUSY.
  - Neither high: stay IDLE with all mem_* = 0.
- BUSY: mem_* held stable.
  - cnt != 0: cnt decrements.
  - cnt == 0: if mem_we == 0, capture mem_rdata into rdata_q. Deassert mem_en, go RESP.
- RESP: pulse the granted port's ready for exactly one cycle, update last_grant, increment that port's grant counter, go IDLE.
  - No arbitration occurs in RESP, because the requester still drives its old request during that cycle.
- rdata_q is updated only on reads. A store leaves it unchanged.
- Requester drops req before ready (illegal but tolerated): the transaction completes and ready still pulses.
- if_ready and d_ready are never high in the same cycle.
- At most one transaction is in flight.

## Timing
- Reset values: if_ready = d_ready = mem_en = mem_we = 0; mem_addr = mem_wdata = if_rdata = d_rdata = 0; grant_cnt_i = grant_cnt_d = 0; state = IDLE; last_grant = I.
- Request first sampled at edge E0 (IDLE):
  - mem_en high from E0 through E0+LATENCY-1, which is LATENCY cycles.
  - ready high for the cycle following edge E0+LATENCY (RESP).
  - Back in IDLE after edge E0+LATENCY+1.
- Latency: ready asserts LATENCY+1 cycles after the request is sampled.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Grant counter visible incremented the cycle after the ready pulse.
- Reset mid-BUSY or mid-RESP:
  - Next cycle is IDLE with all outputs at reset values.
  - No ready pulse is issued and counters are cleared.
  - A partially issued store is outside the arbiter's guarantee.
- LATENCY = 1: BUSY lasts one cycle and rdata is captured in that cycle.
- Counter wrap: 0xFFFFFFFF + 1 = 0x00000000, no saturation.

## Test plan
- Single fetch, LATENCY = 4, if_addr = 0x40, mem_rdata = 0x00A00093: mem_en high for exactly 4 cycles with mem_addr = 0x40 and mem_we = 0. if_ready pulses once, 5 cycles after sampling, with if_rdata = 0x00A00093. grant_cnt_i = 1.
- Store then load on the same address:
  - Store (d_we = 1, 0x100, 0xDEADBEEF): mem_we = 1, mem_wdata = 0xDEADBEEF, d_ready pulse, rdata_q unchanged.
  - Load from 0x100 (memory model returns 0xDEADBEEF): d_rdata = 0xDEADBEEF.
- Simultaneous if_req and d_req held continuously, both re-issued after every ready: grants alternate D, I, D, I; each access takes 6 cycles; after 4 accesses grant_cnt_d = 2 and grant_cnt_i = 2.
- Requester holds req through the RESP cycle and drops it the cycle after: no duplicate mem_en in the RESP cycle. The IDLE cycle is observed between accesses.
- Reset asserted in the 2nd BUSY cycle of a store: the next cycle shows mem_en = 0, no d_ready, and counters = 0. A new fetch afterwards completes normally.
- LATENCY = 1 build: fetch ready arrives 2 cycles after sampling, and mem_en is high for exactly 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between fetch (I) and data (D) ports, D-first with alternation.
// Latency: ready pulses LATENCY+1 cycles after the request is sampled; requests are held by the core until ready.
module mem_port_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   grant_cnt_i,
  output logic [31:0]   grant_cnt_d
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          gnt_d;
  logic          last_d;
  logic [DW-1:0] rdata_q;
  logic          pick_d;

  // Data wins on contention unless it also won the previous grant.
  assign pick_d   = d_req && !(if_req && last_d);
  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_d       <= 1'b0;
      last_d      <= 1'b0;
      rdata_q     <= '0;
      if_ready    <= 1'b0;
      d_ready     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant_cnt_i <= '0;
      grant_cnt_d <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            mem_en    <= 1'b1;
            mem_we    <= pick_d && d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            cnt       <= CNT_INIT;
            gnt_d     <= pick_d;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!mem_we) rdata_q <= mem_rdata;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= !gnt_d;
            d_ready   <= gnt_d;
            state     <= RESP;
          end
        end
        RESP: begin
          // Requester still shows its old request here, so no arbitration this cycle.
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          last_d   <= gnt_d;
          if (gnt_d) grant_cnt_d <= grant_cnt_d + 32'd1;
          else       grant_cnt_i <= grant_cnt_i + 32'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=4 main instance plus a LATENCY=1 instance.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, grant_cnt_i, grant_cnt_d;

  logic        if_req1;
  logic [31:0] if_addr1, mem_rdata1;
  logic        if_ready1, d_ready1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, grant_cnt_i1, grant_cnt_d1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_cnt_i(grant_cnt_i), .grant_cnt_d(grant_cnt_d)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .grant_cnt_i(grant_cnt_i1), .grant_cnt_d(grant_cnt_d1)
  );

  // Word-addressed memory model; word 16 (byte 0x40) holds the fetch instruction.
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 32'h00A00093 : 32'h0;
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata  = (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'h0;
  assign mem_rdata1 = mem_en1 ? 32'hCAFEF00D : 32'h0;

  task automatic test_reset();
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; if_addr1 = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({if_ready, d_ready, mem_en, mem_we} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {if_ready, d_ready, mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0", if_rdata, d_rdata); end
    n_cmp++; if ({grant_cnt_i, grant_cnt_d} !== 64'h0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", grant_cnt_i, grant_cnt_d); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: mem_en got %b want 0", mem_en); end
  endtask

  task automatic test_single_fetch();
    int en_n = 0, first_en = -1, bad_bus = 0, rdy_n = 0, rdy_k = -1, dr_n = 0;
    logic [31:0] rd = 32'h0;
    if_addr = 32'h40; if_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++;
        if (first_en < 0) first_en = k;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0) bad_bus++;
      end
      if (d_ready) dr_n++;
      if (if_ready) begin rdy_n++; rdy_k = k; rd = if_rdata; if_req = 1'b0; end
    end
    n_cmp++; if (en_n != LAT) begin n_bad++; $display("FAIL fetch_en_len: got %0d want %0d", en_n, LAT); end
    n_cmp++; if (first_en != 1) begin n_bad++; $display("FAIL fetch_en_start: got %0d want 1", first_en); end
    n_cmp++; if (bad_bus != 0) begin n_bad++; $display("FAIL fetch_bus: %0d bad cycles want 0", bad_bus); end
    n_cmp++; if (rdy_n != 1 || rdy_k != LAT + 1) begin n_bad++; $display("FAIL fetch_ready: %0d pulses at %0d want 1 at %0d", rdy_n, rdy_k, LAT + 1); end
    n_cmp++; if (rd !== 32'h00A00093) begin n_bad++; $display("FAIL fetch_rdata: got %h want 00a00093", rd); end
    n_cmp++; if (dr_n != 0) begin n_bad++; $display("FAIL fetch_no_dready: got %0d want 0", dr_n); end
    n_cmp++; if (grant_cnt_i !== 32'd1 || grant_cnt_d !== 32'd0) begin n_bad++; $display("FAIL fetch_cnt: got %0d/%0d want 1/0", grant_cnt_i, grant_cnt_d); end
  endtask

  task automatic test_store_load();
    int en_n = 0, bad_bus = 0, rdy_k = -1;
    logic [31:0] rd = 32'h0;
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) bad_bus++;
      end
      if (d_ready) begin rdy_k = k; rd = d_rdata; d_req = 1'b0; end
    end
    n_cmp++; if (en_n != LAT || bad_bus != 0) begin n_bad++; $display("FAIL store_bus: %0d en cycles %0d bad want %0d/0", en_n, bad_bus, LAT); end
    n_cmp++; if (rdy_k != LAT + 1) begin n_bad++; $display("FAIL store_ready: at %0d want %0d", rdy_k, LAT + 1); end
    n_cmp++; if (rd !== 32'h00A00093) begin n_bad++; $display("FAIL store_keeps_rdata: got %h want 00a00093", rd); end
    en_n = 0; bad_bus = 0; rdy_k = -1;
    d_we = 1'b0; d_wdata = 32'h0; d_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h100) bad_bus++;
      end
      if (d_ready) begin rdy_k = k; rd = d_rdata; d_req = 1'b0; end
    end
    n_cmp++; if (en_n != LAT || bad_bus != 0) begin n_bad++; $display("FAIL load_bus: %0d en cycles %0d bad want %0d/0", en_n, bad_bus, LAT); end
    n_cmp++; if (rd !== 32'hDEADBEEF || rdy_k != LAT + 1) begin n_bad++; $display("FAIL load_rdata: got %h at %0d want deadbeef at %0d", rd, rdy_k, LAT + 1); end
    n_cmp++; if (grant_cnt_d !== 32'd2) begin n_bad++; $display("FAIL load_cnt_d: got %0d want 2", grant_cnt_d); end
  endtask

  task automatic test_alternation();
    int en_n = 0, both_n = 0, bad_dat = 0, bad_gap = 0, n_rdy = 0;
    int rk[4];
    logic [3:0] seq = 4'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    if_addr = 32'h40; d_addr = 32'h100; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 40 && n_rdy < 4; k++) begin
      @(negedge clk);
      if (mem_en) en_n++;
      if (if_ready && d_ready) both_n++;
      if (d_ready && d_rdata !== 32'hDEADBEEF) bad_dat++;
      if (if_ready && if_rdata !== 32'h00A00093) bad_dat++;
      if (if_ready || d_ready) begin
        seq[n_rdy] = d_ready;
        rk[n_rdy] = k;
        n_rdy++;
        if (n_rdy == 4) begin if_req = 1'b0; d_req = 1'b0; end
      end
    end
    for (int i = 1; i < n_rdy; i++) if (rk[i] - rk[i-1] != LAT + 2) bad_gap++;
    n_cmp++; if (n_rdy != 4) begin n_bad++; $display("FAIL alt_timeout: %0d readies want 4", n_rdy); end
    n_cmp++; if (seq !== 4'b0101) begin n_bad++; $display("FAIL alt_order: got %b want 0101 (bit0 first, 1=D)", seq); end
    n_cmp++; if (rk[0] != LAT + 1 || bad_gap != 0) begin n_bad++; $display("FAIL alt_timing: first %0d bad gaps %0d want %0d/0", rk[0], bad_gap, LAT + 1); end
    n_cmp++; if (both_n != 0) begin n_bad++; $display("FAIL alt_both_ready: got %0d want 0", both_n); end
    n_cmp++; if (bad_dat != 0) begin n_bad++; $display("FAIL alt_data: %0d bad want 0", bad_dat); end
    n_cmp++; if (en_n != 4 * LAT) begin n_bad++; $display("FAIL alt_en_cycles: got %0d want %0d", en_n, 4 * LAT); end
    repeat (2) @(negedge clk);
    n_cmp++; if (grant_cnt_d !== 32'd2 || grant_cnt_i !== 32'd2) begin n_bad++; $display("FAIL alt_cnt: got i=%0d d=%0d want 2/2", grant_cnt_i, grant_cnt_d); end
  endtask

  task automatic test_hold_through_resp();
    int en_n = 0, rdy_n = 0, rdy_k = -1;
    logic en_resp = 1'bx, en_idle = 1'bx;
    if_addr = 32'h40; if_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_en) en_n++;
      if (rdy_k > 0 && k == rdy_k + 1) begin en_idle = mem_en; if_req = 1'b0; end
      if (if_ready) begin rdy_n++; rdy_k = k; en_resp = mem_en; end
    end
    n_cmp++; if (rdy_n != 1 || rdy_k != LAT + 1) begin n_bad++; $display("FAIL hold_ready: %0d pulses at %0d want 1 at %0d", rdy_n, rdy_k, LAT + 1); end
    n_cmp++; if (en_resp !== 1'b0 || en_idle !== 1'b0) begin n_bad++; $display("FAIL hold_gap: mem_en resp=%b idle=%b want 0/0", en_resp, en_idle); end
    n_cmp++; if (en_n != LAT) begin n_bad++; $display("FAIL hold_dup: en cycles %0d want %0d", en_n, LAT); end
  endtask

  task automatic test_reset_mid_busy();
    int act_n = 0, rdy_k = -1;
    logic [31:0] rd = 32'h0;
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h5555AAAA; d_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, d_ready, if_ready} !== 4'b0) begin n_bad++; $display("FAIL rst_busy_ctl: got %b want 0000", {mem_en, mem_we, d_ready, if_ready}); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_busy_addr: got %h want 0", mem_addr); end
    n_cmp++; if (grant_cnt_i !== 32'd0 || grant_cnt_d !== 32'd0) begin n_bad++; $display("FAIL rst_busy_cnt: got %0d/%0d want 0/0", grant_cnt_i, grant_cnt_d); end
    reset = 1'b0; d_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d_ready || if_ready || mem_en) act_n++;
    end
    n_cmp++; if (act_n != 0) begin n_bad++; $display("FAIL rst_busy_quiet: %0d active cycles want 0", act_n); end
    if_addr = 32'h40; if_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (if_ready) begin rdy_k = k; rd = if_rdata; if_req = 1'b0; end
    end
    n_cmp++; if (rdy_k != LAT + 1 || rd !== 32'h00A00093) begin n_bad++; $display("FAIL rst_busy_refetch: at %0d data %h want %0d/00a00093", rdy_k, rd, LAT + 1); end
    n_cmp++; if (grant_cnt_i !== 32'd1 || grant_cnt_d !== 32'd0) begin n_bad++; $display("FAIL rst_busy_refetch_cnt: got %0d/%0d want 1/0", grant_cnt_i, grant_cnt_d); end
  endtask

  task automatic test_latency1();
    int en_n = 0, bad_bus = 0, rdy_k = -1, rdy_n = 0, dr_n = 0;
    logic [31:0] rd = 32'h0;
    if_addr1 = 32'h80; if_req1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_en1) begin
        en_n++;
        if (k != 1 || mem_addr1 !== 32'h80 || mem_we1 !== 1'b0) bad_bus++;
      end
      if (d_ready1) dr_n++;
      if (if_ready1) begin rdy_n++; rdy_k = k; rd = if_rdata1; if_req1 = 1'b0; end
    end
    n_cmp++; if (en_n != 1 || bad_bus != 0) begin n_bad++; $display("FAIL lat1_en: %0d cycles %0d bad want 1/0", en_n, bad_bus); end
    n_cmp++; if (rdy_n != 1 || rdy_k != 2) begin n_bad++; $display("FAIL lat1_ready: %0d pulses at %0d want 1 at 2", rdy_n, rdy_k); end
    n_cmp++; if (rd !== 32'hCAFEF00D || d_rdata1 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lat1_rdata: got %h/%h want cafef00d", rd, d_rdata1); end
    n_cmp++; if (grant_cnt_i1 !== 32'd1 || grant_cnt_d1 !== 32'd0 || dr_n != 0) begin n_bad++; $display("FAIL lat1_cnt: got %0d/%0d dready %0d want 1/0/0", grant_cnt_i1, grant_cnt_d1, dr_n); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_alternation();
    test_hold_through_resp();
    test_reset_mid_busy();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
